quad_encoder_array_mmio: RTL
============================

# quad_encoder_array_mmio

Parametrised multi-channel successor to the single-channel encoder MMIO peripheral. Instantiates NUM_CH independent quadrature decoders, each with input synchronisation, a glitch filter, x4 decoding, illegal-transition detection and a windowed velocity measurement. All channels share one memory-mapped register bus and a single level interrupt toward the CPU.

## Interface
- NUM_CH, 4: number of encoder channels, 1..16.
- POS_W, 32: position and velocity width in bits, 8..32. Values are zero-extended to 32 bits on read.
- SYNC_STAGES, 2: flip-flop synchroniser depth on enc_a/enc_b, at least 2.
- FILT_LEN, 3: consecutive identical synchronised samples required before a new {A,B} pair is accepted, at least 1.
- WIN_RST, 100000: reset value of the global WINDOW register, in clk cycles.

- clk  in  1  single clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_addr  in  32  byte address; only [8:0] is decoded.
- bus_we  in  1  write strobe, sampled each rising edge.
- bus_re  in  1  read strobe, sampled each rising edge.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  registered read data.
- enc_a  in  NUM_CH  channel-n A phase in bit n; asynchronous.
- enc_b  in  NUM_CH  channel-n B phase in bit n; asynchronous.
- irq  out  1  level interrupt: OR over channels of (ERR & IRQ_EN).

## Operation
Register map: channel n occupies base n*0x10. Unmapped addresses read 0 and ignore writes.
- +0x0 CTRL (RW)
  - bit0 ENABLE.
  - bit1 CLR_POS: write-1 action, always reads 0.
  - bit2 IRQ_EN.
  - bit3 REVERSE: swaps the counting sense.
- +0x4 STATUS
  - bit0 DIR (RO): 1 = last accepted step was forward.
  - bit1 ERR: sticky; write 1 to clear.
- +0x8 POSITION (RW): a write preloads the counter.
- +0xC VELOCITY (RO): signed position delta over the last window.
- 0x100 WINDOW (RW, global): velocity window length in clk cycles.

Per-channel pipeline:
- Synchroniser: SYNC_STAGES flip-flops on enc_a and enc_b.
- Filter: counts consecutive synchronised samples equal to the pending value. When the count reaches FILT_LEN, the pair becomes the accepted state `cur`.
- Decoder: compares `cur` with the previous accepted state `prv` each cycle.
  - Forward, +1: 00→01→11→10→00.
  - Reverse, −1: the opposite sequence.
  - No change: no action.
  - Both bits changed: ERR is set to 1 and the position is unchanged.
  - REVERSE=1 negates the ±1.
- `prv` tracks `cur` even when ENABLE=0. ERR detection is also active when ENABLE=0. Re-enabling therefore never produces a spurious count.
- Position updates only when ENABLE=1. Arithmetic is two's complement modulo 2^POS_W: +1 at max wraps to 0, −1 at 0 wraps to all-ones.
- DIR updates on every counted step and holds otherwise.
- Priority in one cycle: CLR_POS, then POSITION write, then count step.
  - A step lost to clear or preload is dropped.
  - DIR still updates for the dropped step.
- ERR priority: setting by an illegal transition wins over a same-cycle W1C.

Velocity:
- One global window counter counts 0..WINDOW−1.
- At the terminal count, for every channel: VELOCITY ← POSITION − SNAP (mod 2^POS_W), then SNAP ← POSITION.
- WINDOW=0 stops the counter; VELOCITY holds its value.
- A write to WINDOW restarts the counter at 0.
- CLR_POS and POSITION writes also set SNAP to the new position, so the next VELOCITY excludes the jump.

## Timing
- Reset values (asserted asynchronously):
  - All CTRL fields 0.
  - POSITION, SNAP, VELOCITY, DIR, ERR: 0.
  - Filter and `prv` states: 00.
  - WINDOW = WIN_RST.
  - bus_rdata = 0, irq = 0.
- Read: bus_rdata is loaded on the rising edge where bus_re=1 and is valid after that edge. It holds its value while bus_re=0. A read in the same cycle as a write returns the pre-write value.
- Write: takes effect at the rising edge where bus_we=1. Holding bus_we high for several cycles repeats the write; each repeated CLR_POS is harmless.
- Pin-to-POSITION latency: SYNC_STAGES + FILT_LEN + 1 cycles from an input change that stays stable. With defaults this is 6 cycles.
- Pulses shorter than FILT_LEN cycles after synchronisation are rejected.
- irq is registered: it asserts 1 cycle after ERR sets and deasserts 1 cycle after the W1C.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C/0x100 → 0, 0, 0, 0, WIN_RST (100000).
- Channel 0: ENABLE=1, then 5 forward cycles with each phase held 4 clk → POSITION 0x14, DIR=1. Then 2 reverse cycles → 0x0C, DIR=0. Channel 1 POSITION stays 0 throughout.
- Channel 2: preload POSITION=0xFFFFFFFF, then 1 forward step → 0x00000000. Then 1 reverse step → 0xFFFFFFFF.
- Channel 0: inject 1-cycle glitches on A → POSITION unchanged. Then a 00→11 jump held stable → ERR=1, irq=0. Then IRQ_EN=1 → irq=1. Then W1C of STATUS → ERR=0, irq=0.
- WINDOW=50, channel 3 receives 10 forward steps within one window → VELOCITY=10. Next window with no motion → 0. With REVERSE=1 and the same stimulus → −10 (0xFFFFFFF6).
- CLR_POS issued on the same edge as a counted step → POSITION=0. Then ENABLE=0 with 20 steps applied → POSITION=0, and no count occurs on re-enable.

Source files
------------

// File: rtl/quad_encoder_array_mmio.sv
// Multi-channel quadrature decoder with per-channel position, velocity and error state.
// All channels share one register bus and one level interrupt.
module quad_encoder_array_mmio #(
  parameter int NUM_CH      = 4,
  parameter int POS_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int WIN_RST     = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  output logic              irq
);
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [31:0] window_q, win_cnt_q;
  logic [31:0] rdata_d, rdata_q;
  logic        irq_q;
  logic        win_tick;
  logic        win_sel;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_idx;
  logic        unused_addr;

  logic [31:0]       ctrl_rd [NUM_CH];
  logic [31:0]       stat_rd [NUM_CH];
  logic [31:0]       pos_rd  [NUM_CH];
  logic [31:0]       vel_rd  [NUM_CH];
  logic [NUM_CH-1:0] err_irq;

  assign win_sel     = (bus_addr[8:2] == 7'h40);
  assign ch_idx      = bus_addr[7:4];
  assign reg_idx     = bus_addr[3:2];
  assign unused_addr = ^{bus_addr[31:9], bus_addr[1:0]};
  assign win_tick    = (window_q != 32'd0) && (win_cnt_q == window_q - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_q  <= 32'(WIN_RST);
      win_cnt_q <= 32'd0;
    end else if (bus_we && win_sel) begin
      window_q  <= bus_wdata;
      win_cnt_q <= 32'd0;
    end else if (window_q != 32'd0) begin
      win_cnt_q <= win_tick ? 32'd0 : win_cnt_q + 32'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]       sync_q [SYNC_STAGES];
      logic [1:0]       pend_q, pend_d, cur_q, cur_d, prv_q;
      logic [FW-1:0]    fcnt_q, fcnt_d;
      logic             en_q, ie_q, rev_q;
      logic             dir_q, dir_d, err_q, err_d;
      logic [POS_W-1:0] pos_q, pos_d, snap_q, snap_d, vel_q, vel_d;
      logic             sel, wr_ctrl, wr_stat, wr_pos, clr;
      logic [1:0]       idx_cur, idx_prv, delta;
      logic             fwd, bwd, ill, step, up;
      logic [31:0]      pos_ext, vel_ext;

      assign sel     = bus_we && !bus_addr[8] && (ch_idx == 4'(gi));
      assign wr_ctrl = sel && (reg_idx == 2'd0);
      assign wr_stat = sel && (reg_idx == 2'd1);
      assign wr_pos  = sel && (reg_idx == 2'd2);
      assign clr     = wr_ctrl && bus_wdata[1];

      // Gray state mapped to a 0..3 phase index, so the step is the index difference mod 4.
      assign idx_cur = {cur_q[1], cur_q[1] ^ cur_q[0]};
      assign idx_prv = {prv_q[1], prv_q[1] ^ prv_q[0]};
      assign delta   = idx_cur - idx_prv;
      assign fwd     = (delta == 2'd1);
      assign bwd     = (delta == 2'd3);
      assign ill     = (delta == 2'd2);
      assign step    = en_q && (fwd || bwd);
      assign up      = fwd ^ rev_q;

      always_comb begin
        pend_d = pend_q;
        fcnt_d = fcnt_q;
        cur_d  = cur_q;
        if (sync_q[SYNC_STAGES-1] != pend_q) begin
          pend_d = sync_q[SYNC_STAGES-1];
          fcnt_d = FW'(1);
        end else if (fcnt_q < FW'(FILT_LEN)) begin
          fcnt_d = fcnt_q + FW'(1);
        end
        if (fcnt_d >= FW'(FILT_LEN)) cur_d = pend_d;
      end

      always_comb begin
        pos_d  = pos_q;
        snap_d = snap_q;
        vel_d  = vel_q;
        dir_d  = dir_q;
        err_d  = err_q;
        if (win_tick) begin
          vel_d  = pos_q - snap_q;
          snap_d = pos_q;
        end
        if (step) dir_d = up;
        // A clear or preload swallows a same-cycle step and rebases the velocity snapshot.
        if (clr) begin
          pos_d  = '0;
          snap_d = '0;
        end else if (wr_pos) begin
          pos_d  = bus_wdata[POS_W-1:0];
          snap_d = bus_wdata[POS_W-1:0];
        end else if (step) begin
          pos_d = up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
        if (ill)                         err_d = 1'b1;
        else if (wr_stat && bus_wdata[1]) err_d = 1'b0;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 2'b00;
          pend_q <= 2'b00;
          fcnt_q <= '0;
          cur_q  <= 2'b00;
          prv_q  <= 2'b00;
          en_q   <= 1'b0;
          ie_q   <= 1'b0;
          rev_q  <= 1'b0;
          dir_q  <= 1'b0;
          err_q  <= 1'b0;
          pos_q  <= '0;
          snap_q <= '0;
          vel_q  <= '0;
        end else begin
          sync_q[0] <= {enc_a[gi], enc_b[gi]};
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
          pend_q <= pend_d;
          fcnt_q <= fcnt_d;
          cur_q  <= cur_d;
          prv_q  <= cur_q;
          if (wr_ctrl) begin
            en_q  <= bus_wdata[0];
            ie_q  <= bus_wdata[2];
            rev_q <= bus_wdata[3];
          end
          dir_q  <= dir_d;
          err_q  <= err_d;
          pos_q  <= pos_d;
          snap_q <= snap_d;
          vel_q  <= vel_d;
        end
      end

      always_comb begin
        pos_ext = '0;
        vel_ext = '0;
        pos_ext[POS_W-1:0] = pos_q;
        vel_ext[POS_W-1:0] = vel_q;
      end

      assign ctrl_rd[gi] = {28'd0, rev_q, ie_q, 1'b0, en_q};
      assign stat_rd[gi] = {30'd0, err_q, dir_q};
      assign pos_rd[gi]  = pos_ext;
      assign vel_rd[gi]  = vel_ext;
      assign err_irq[gi] = err_q & ie_q;
    end
  endgenerate

  always_comb begin
    rdata_d = '0;
    if (win_sel) begin
      rdata_d = window_q;
    end else if (!bus_addr[8]) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 4'(c)) begin
          case (reg_idx)
            2'd0:    rdata_d = ctrl_rd[c];
            2'd1:    rdata_d = stat_rd[c];
            2'd2:    rdata_d = pos_rd[c];
            default: rdata_d = vel_rd[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (bus_re) rdata_q <= rdata_d;
      irq_q <= |err_irq;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq       = irq_q;
endmodule
